int_capture: RTL
================

INT_CAPTURE -- requirements
Module: int_capture

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per request line (legal 2..4).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port irq_in  input  4  external interrupt request lines, asynchronous to clk; bit0 = port 1 (highest priority) .. bit3 = port 4.
REQ-005 SHALL have port mask_we  input  1  write strobe for the mask register.
REQ-006 SHALL have port mask_wdata  input  4  new mask value; 1 = port enabled.
REQ-007 SHALL have port s_interrup  input  1  one-cycle acceptance pulse from the interrupt manager.
REQ-008 SHALL have port fin  input  1  one-cycle end-of-subroutine pulse from the control unit.
REQ-009 SHALL have ports iport1, iport2, iport3, iport4  output  1 each  registered pending-and-enabled requests to the interrupt manager.
REQ-010 SHALL have port pending  output  4  raw pending register, for status read.
REQ-011 SHALL have port in_service  output  1  high while an accepted interrupt subroutine runs.

Function
REQ-012 SHALL pass each irq_in bit through SYNC_STAGES flops; edge detect on synchronized value against one further delayed copy.
REQ-013 SHALL set pending[i] on a synchronized rising edge of irq_in[i], independent of mask; levels held high do not re-trigger.
REQ-014 SHALL drive iport(i+1) = pending[i] & mask[i], registered (one cycle after pending/mask update).
REQ-015 SHALL implement FSM IDLE/SERVICE: IDLE -> SERVICE on s_interrup; SERVICE -> IDLE on fin; in_service = (state == SERVICE).
REQ-016 SHALL, on s_interrup in IDLE, clear the pending bit of the lowest-index set bit of (pending & mask) and record that index in svc_id.
REQ-017 SHALL ignore s_interrup in SERVICE and fin in IDLE.
REQ-018 SHALL, on s_interrup with (pending & mask) == 0, enter SERVICE without clearing any bit.
REQ-019 SHALL, when a set edge and an acceptance clear hit the same bit in one cycle, keep the bit set.
REQ-020 SHALL latency: irq_in edge to iport high = SYNC_STAGES + 2 clk cycles (mask enabled).
REQ-021 SHALL update mask on mask_we in the same cycle; masking a pending bit hides it from iport but does not clear it; unmasking re-exposes it.
REQ-022 SHALL, on s_interrup and fin in the same cycle in SERVICE, go IDLE; in IDLE, go SERVICE.

Reset
REQ-023 SHALL, on reset low, asynchronously clear synchronizers, edge registers, pending, svc_id, and set state to IDLE.
REQ-024 SHALL reset mask to 4'b1111 (all ports enabled).
REQ-025 SHALL reset outputs: iport1..4 = 0, pending = 0, in_service = 0.
REQ-026 SHALL, on reset asserted mid-SERVICE, drop in_service immediately and discard all pending requests.

Configuration
REQ-027 SHALL, with INT_CAPTURE_OVF_EN defined, add output ovf[3:0]: ovf[i] set sticky when an edge arrives while pending[i] already set; cleared by mask_we with mask_wdata[i] = 0; reset 0.
REQ-028 SHALL, without INT_CAPTURE_OVF_EN, omit port ovf and its logic; repeated edges merge silently into one pending request.

Verification
REQ-029 SHALL cover: irq_in = 4'b0001 rising at cycle 0 -> iport1 high at cycle 4 (SYNC_STAGES=2), pending = 4'b0001.
REQ-030 SHALL cover: pending = 4'b0110, s_interrup pulse -> pending = 4'b0100, in_service = 1, iport2 low, iport3 still high.
REQ-031 SHALL cover: mask_wdata = 4'b1110 with pending = 4'b0001 -> iport1 low, pending unchanged; mask back to 4'b1111 -> iport1 high next cycle.
REQ-032 SHALL cover: second s_interrup in SERVICE -> pending unchanged; fin pulse -> in_service = 0 next cycle.
REQ-033 SHALL cover: new edge on port 1 in same cycle s_interrup clears port 1 -> pending[0] stays 1.
REQ-034 SHALL cover: reset low during SERVICE with pending = 4'b1010 -> in_service, pending, iport all 0 without clock edge; with INT_CAPTURE_OVF_EN, two edges on port 4 before acceptance -> ovf = 4'b1000.

Source files
------------

// File: rtl/int_capture.sv
// Four-line external interrupt capture: synchronizers, edge-triggered pending latches, mask and
// a single-level IDLE/SERVICE handshake. Define INT_CAPTURE_OVF_EN to add sticky overflow flags.
module int_capture #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq_in,
  input  logic       mask_we,
  input  logic [3:0] mask_wdata,
  input  logic       s_interrup,
  input  logic       fin,
`ifdef INT_CAPTURE_OVF_EN
  output logic [3:0] ovf,
`endif
  output logic       iport1,
  output logic       iport2,
  output logic       iport3,
  output logic       iport4,
  output logic [3:0] pending,
  output logic       in_service,
  output logic [1:0] svc_id
);

  typedef enum logic [0:0] {StIdle, StService} state_e;

  state_e     state_q, state_d;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] prev_q;
  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] iport_q;
  logic [1:0] svc_id_q, svc_id_d;
  logic [3:0] synced, rise, req, clr;
  logic [1:0] acc_idx;
  logic       acc_hit, accept;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;
  assign req    = pending_q & mask_q;

  // Lowest index wins: port 1 has the highest priority.
  always_comb begin
    acc_hit = 1'b0;
    acc_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        acc_hit = 1'b1;
        acc_idx = 2'(i);
      end
    end
  end

  assign accept = (state_q == StIdle) && s_interrup && acc_hit;
  assign clr    = accept ? (4'b0001 << acc_idx) : 4'b0000;

  always_comb begin
    state_d   = state_q;
    pending_d = (pending_q & ~clr) | rise;  // a fresh edge beats a same-cycle clear
    mask_d    = mask_we ? mask_wdata : mask_q;
    svc_id_d  = accept ? acc_idx : svc_id_q;
    unique case (state_q)
      StIdle:    if (s_interrup) state_d = StService;
      StService: if (fin)        state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= 4'b1111;
      iport_q   <= '0;
      svc_id_q  <= '0;
      state_q   <= StIdle;
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q    <= synced;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      iport_q   <= pending_q & mask_q;
      svc_id_q  <= svc_id_d;
      state_q   <= state_d;
    end
  end

`ifdef INT_CAPTURE_OVF_EN
  logic [3:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (mask_we) ovf_d = ovf_d & mask_wdata;
    ovf_d = ovf_d | (rise & pending_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign iport1     = iport_q[0];
  assign iport2     = iport_q[1];
  assign iport3     = iport_q[2];
  assign iport4     = iport_q[3];
  assign pending    = pending_q;
  assign in_service = (state_q == StService);
  assign svc_id     = svc_id_q;

endmodule
